// File: rtl/fetch_unit.sv
// Program counter and fetch control: relative branch, absolute jump, call/return
// stack, stall, and a latched RUN/HALTED/FAULT state. All outputs decode registered state.
module fetch_unit #(
    parameter int              PC_W      = 8,
    parameter int              OFF_W     = 3,
    parameter int              OFF_SHIFT = 2,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             CLK,
    input  logic             Init,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             Resume,
    input  logic             Branch,
    input  logic [OFF_W-1:0] Target,
    input  logic             Jump,
    input  logic             Call,
    input  logic             Ret,
    input  logic [PC_W-1:0]  JumpAddr,
    output logic [PC_W-1:0]  PC,
    output logic             Halted,
    output logic             Fault,
    output logic             RasEmpty,
    output logic             RasFull
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic             push;
    logic [PC_W-1:0]  pop_val;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  br_off;

    assign pc_inc = pc_q + PC_ONE;
    // Size cast of a signed value sign-extends; the shift then truncates to PC_W.
    assign br_off = PC_W'($signed(Target)) << OFF_SHIFT;

    always_comb begin
        pop_val = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (cnt_q == CNT_W'(i + 1)) pop_val = ras_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_HALT;
                end else if (Stall) begin
                    state_d = ST_RUN;
                end else if (Ret) begin
                    if (cnt_q == '0) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d  = pop_val;
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else if (Call) begin
                    if (cnt_q == CNT_FULL) begin
                        state_d = ST_FAULT;
                    end else begin
                        push  = 1'b1;
                        cnt_d = cnt_q + CNT_ONE;
                        pc_d  = JumpAddr;
                    end
                end else if (Jump) begin
                    pc_d = JumpAddr;
                end else if (Branch) begin
                    pc_d = pc_q + br_off;
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_HALT: begin
                if (Resume) state_d = ST_RUN;
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Init) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Entries above the count are don't-care, so the stack body needs no reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (!Init && push && cnt_q == CNT_W'(i)) ras_q[i] <= pc_inc;
        end
    end

    assign PC       = pc_q;
    assign Halted   = (state_q != ST_RUN);
    assign Fault    = (state_q == ST_FAULT);
    assign RasEmpty = (cnt_q == '0);
    assign RasFull  = (cnt_q == CNT_FULL);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural model feeds an expected-state queue each cycle,
// checked against the DUT after the edge; directed checks pin the documented scenarios.
module tb_fetch_unit;
    logic       CLK = 1'b0;
    logic       Init = 1'b0, Stall = 1'b0, Halt = 1'b0, Resume = 1'b0;
    logic       Branch = 1'b0, Jump = 1'b0, Call = 1'b0, Ret = 1'b0;
    logic [2:0] Target = '0;
    logic [7:0] JumpAddr = '0;
    logic [7:0] PC;
    logic       Halted, Fault, RasEmpty, RasFull;

    fetch_unit dut (
        .CLK(CLK), .Init(Init), .Stall(Stall), .Halt(Halt), .Resume(Resume),
        .Branch(Branch), .Target(Target), .Jump(Jump), .Call(Call), .Ret(Ret),
        .JumpAddr(JumpAddr), .PC(PC), .Halted(Halted), .Fault(Fault),
        .RasEmpty(RasEmpty), .RasFull(RasFull)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] pc;
        logic       halted, fault, empty, full;
    } exp_t;

    exp_t       sbq[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] m_pc = 8'd0;
    int         m_st = 0;   // 0 run, 1 halted, 2 fault
    logic [7:0] m_stk[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clr();
        Init = 0; Stall = 0; Halt = 0; Resume = 0; Branch = 0;
        Jump = 0; Call = 0; Ret = 0; Target = '0; JumpAddr = '0;
    endtask

    task automatic model();
        logic [7:0] off;
        off = {{5{Target[2]}}, Target} << 2;
        if (Init) begin
            m_pc = 8'd0; m_st = 0; m_stk.delete();
        end else if (m_st == 0) begin
            if (Halt) m_st = 1;
            else if (Stall) m_st = 0;
            else if (Ret) begin
                if (m_stk.size() == 0) m_st = 2;
                else m_pc = m_stk.pop_back();
            end else if (Call) begin
                if (m_stk.size() == 4) m_st = 2;
                else begin
                    m_stk.push_back(m_pc + 8'd1);
                    m_pc = JumpAddr;
                end
            end else if (Jump) m_pc = JumpAddr;
            else if (Branch) m_pc = m_pc + off;
            else m_pc = m_pc + 8'd1;
        end else if (m_st == 1) begin
            if (Resume) m_st = 0;
        end
    endtask

    // One clock: model the edge, queue the expectation, then compare after the edge.
    task automatic tick();
        exp_t e;
        model();
        e.pc = m_pc; e.halted = (m_st != 0); e.fault = (m_st == 2);
        e.empty = (m_stk.size() == 0); e.full = (m_stk.size() == 4);
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        e = sbq.pop_front();
        chk("pc", PC, e.pc);
        chk("halted", Halted, e.halted);
        chk("fault", Fault, e.fault);
        chk("ras_empty", RasEmpty, e.empty);
        chk("ras_full", RasFull, e.full);
    endtask

    task automatic go_to(input logic [7:0] a);
        clr(); Jump = 1; JumpAddr = a; tick(); clr();
    endtask

    task automatic do_init();
        clr(); Init = 1; tick(); clr();
    endtask

    initial begin
        @(posedge CLK); #1;
        // Reset then sequential fetch
        do_init();
        chk("rst_pc", PC, 0); chk("rst_empty", RasEmpty, 1); chk("rst_full", RasFull, 0);
        chk("rst_halted", Halted, 0); chk("rst_fault", Fault, 0);
        for (int i = 1; i <= 5; i++) begin
            tick(); chk("seq_pc", PC, i);
        end

        // Branches, negative offset and wrap
        go_to(8'd10); Branch = 1; Target = 3'b111; tick(); chk("br_neg", PC, 6);
        go_to(8'd250); Branch = 1; Target = 3'b011; tick(); chk("br_wrap", PC, 6);
        go_to(8'd255); clr(); tick(); chk("inc_wrap", PC, 0);

        // Call / return, then overflow fault
        go_to(8'd5); Call = 1; JumpAddr = 8'd40; tick();
        chk("call_pc", PC, 40); chk("call_empty", RasEmpty, 0);
        clr(); Ret = 1; tick(); chk("ret_pc", PC, 6); clr();
        for (int i = 0; i < 4; i++) begin
            Call = 1; JumpAddr = 8'(8'd100 + 8'(i * 10)); tick();
        end
        chk("depth4_full", RasFull, 1); chk("depth4_pc", PC, 130);
        tick(); chk("ovf_fault", Fault, 1); chk("ovf_halted", Halted, 1); chk("ovf_pc", PC, 130);
        clr(); Resume = 1; tick(); chk("fault_sticky", Fault, 1);
        do_init(); chk("init_pc", PC, 0); chk("init_fault", Fault, 0);

        // Underflow fault from reset
        Ret = 1; tick(); chk("unf_fault", Fault, 1); chk("unf_pc", PC, 0);
        clr(); Resume = 1; tick(); chk("unf_sticky", Fault, 1);
        do_init(); chk("unf_clear", Fault, 0);

        // Halt beats branch; resume keeps PC for one cycle
        go_to(8'd7); Halt = 1; Branch = 1; Target = 3'b001; tick();
        chk("halt_pc", PC, 7); chk("halt_flag", Halted, 1);
        clr(); Branch = 1; Jump = 1; JumpAddr = 8'd77; Halt = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("halt_hold_pc", PC, 7); chk("halt_hold", Halted, 1);
        end
        clr(); Resume = 1; tick(); chk("resume_halted", Halted, 0); chk("resume_pc", PC, 7);
        tick(); chk("resume_run", PC, 8);

        // Stall holds PC; Init overrides a stall
        go_to(8'd3); Stall = 1; Jump = 1; JumpAddr = 8'd99; tick(); chk("stall_pc", PC, 3);
        Stall = 0; tick(); chk("unstall_pc", PC, 99);
        Stall = 1; Init = 1; tick(); chk("init_in_stall", PC, 0); clr();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            Init     = ($urandom_range(0, 60) == 0);
            Stall    = ($urandom_range(0, 7) == 0);
            Halt     = ($urandom_range(0, 15) == 0);
            Resume   = ($urandom_range(0, 3) == 0);
            Branch   = $urandom_range(0, 1) == 1;
            Jump     = ($urandom_range(0, 4) == 0);
            Call     = ($urandom_range(0, 4) == 0);
            Ret      = ($urandom_range(0, 4) == 0);
            Target   = 3'($urandom);
            JumpAddr = 8'($urandom);
            tick();
        end
        clr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
